branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumer end of the branch predictor interface.
- Captures each fetch-stage prediction (predict bit and target) and carries it alongside the instruction through two shadow stages (IF/ID, ID/EX).
- In EX, compares the prediction with the actual branch outcome, raises a redirect on misprediction, and issues the training update (update/br/update_pc/update_target) back to the predictor.
- Keeps branch and mispredict statistics counters.

Parameters:
- CNT_WIDTH, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_valid  in  1  valid instruction leaving IF this cycle
- if_pc  in  32  PC of that instruction
- if_predict  in  1  predictor said taken
- if_predict_target  in  32  predicted target (don't-care if if_predict=0)
- stall  in  1  pipeline stall; shadow stages hold
- ex_resolve  in  1  instruction in EX is a branch/jump resolving now
- ex_taken  in  1  actual direction
- ex_target  in  32  actual taken target
- redirect  out  1  misprediction; fetch must restart at redirect_pc
- redirect_pc  out  32  correct next PC
- update  out  1  one-cycle training strobe to predictor
- br  out  1  actual direction for update
- update_pc  out  32  PC being trained
- update_target  out  32  target being trained
- stat_branches  out  CNT_WIDTH  resolved branches
- stat_mispredicts  out  CNT_WIDTH  redirects raised

Behaviour:
Reset and stages:
- Reset rst is asynchronous, active-high; clock clk.
- On reset, both stages are invalid and all outputs are 0, including both counters.
- Shadow stages: on each posedge with stall=0, IF/ID <= {if_valid, if_pc, if_predict, if_predict_target} and ID/EX <= IF/ID.
- With stall=1, both stages hold.

Resolution (combinational, in the EX cycle):
- Resolution is active only when the ID/EX entry is valid and stall=0. If stall=1, redirect=0 and no update or count is scheduled; resolution happens on the first unstalled cycle.
- Mispredict cases for a valid entry with ex_resolve=1:
  - predict=1, ex_taken=0 → mispredict, redirect_pc = pc+4.
  - predict=0, ex_taken=1 → mispredict, redirect_pc = ex_target.
  - predict=1, ex_taken=1, predicted target != ex_target → mispredict, redirect_pc = ex_target.
  - Otherwise, no redirect.
- Valid entry with ex_resolve=0 and predict=1 (alias hit on a non-branch) → mispredict, redirect_pc = pc+4.
- Valid entry with ex_resolve=0 and predict=0 → nothing.
- pc+4 wraps modulo 2^32.
- When no redirect is raised, redirect_pc = 0.

Flush:
- At the posedge ending a redirect cycle, both stages become invalid. The IF entry presented that cycle is dropped, because it is wrong-path.
- This gives a 2-cycle resolution shadow after each redirect.

Update (registered):
- One cycle after a resolving cycle, update=1 for exactly one cycle.
- Fields: br=ex_taken, update_pc=pc, update_target=ex_target, all sampled in the resolving cycle.
- The alias case also emits an update with br=0 and update_target=0.
- Otherwise update=0. br and update_pc/update_target hold their last values.

Counters (update the cycle after resolution, saturating at all-ones):
- stat_branches += 1 per ex_resolve resolution.
- stat_mispredicts += 1 per redirect.

Boundary conditions:
- Back-to-back resolving cycles yield back-to-back update pulses.
- Reset mid-operation discards any pending update: no pulse after reset deasserts.
- if_valid=0 bubbles propagate as invalid entries.
- An EX entry is resolved at most once: it advances or is flushed on the same edge.

Decomposition:
- Package branch_pkg:
  - typedef pred_entry_t {valid, pc[31:0], predict, target[31:0]}
  - localparam PC_STEP = 4
- Sub-module pred_stage_reg: one shadow stage with stall hold and flush clear. Instantiated twice (IF/ID, ID/EX).
- Compare/redirect logic, update register and counters stay in branch_resolver.

Test Plan:
1. Correct prediction: IF pc=0x100, predict=1, target=0x200; two unstalled cycles later ex_resolve=1, taken=1, target=0x200 → redirect=0; next cycle update=1, br=1, update_pc=0x100, update_target=0x200; stat_branches=1, stat_mispredicts=0.
2. Predicted taken, not taken: pc=0x100, predict=1 → EX taken=0 → redirect=1, redirect_pc=0x104; next cycle update=1, br=0; both stages invalid; a following IF entry presented in the redirect cycle never resolves.
3. Wrong target: pc=0x40, predict=1, target=0x80; EX taken=1, target=0xC0 → redirect_pc=0xC0; stat_mispredicts=1.
4. Stall in EX: a valid mispredicting entry sits in EX with stall=1 for 3 cycles → redirect=0 and no update during the stall; on the cycle stall drops → redirect=1 exactly once and one update pulse.
5. Alias plus wrap: pc=0xFFFFFFFC, predict=1, ex_resolve=0 → redirect_pc=0x00000000; update=1, br=0; stat_branches unchanged, stat_mispredicts +1.
6. Reset mid-flight: assert rst in the cycle after a resolving cycle → update=0 immediately; counters=0; no update pulse after rst deasserts.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver.
//   pred_entry_t : one shadow-stage entry carried alongside an instruction
//                  {valid, pc, predict, target}
//   PC_STEP      : fall-through distance to the next sequential instruction
package branch_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        predict;
      logic [31:0] target;
   } pred_entry_t;

   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pred_stage_reg.sv
// One shadow pipeline stage holding a fetch-time prediction.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (entry invalid)
//   stall         : hold the current entry
//   flush         : invalidate the entry at this edge (wrong-path)
//   d_valid/d_pc/d_predict/d_target : entry from the previous stage
//   q_valid/q_pc/q_predict/q_target : registered entry
module pred_stage_reg
   import branch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        d_valid,
   input  logic [31:0] d_pc,
   input  logic        d_predict,
   input  logic [31:0] d_target,
   output logic        q_valid,
   output logic [31:0] q_pc,
   output logic        q_predict,
   output logic [31:0] q_target
);

   pred_entry_t ent;

   // Stall wins over flush: a redirect is only ever raised while unstalled,
   // so the two never coincide, but holding is the safe choice if they did.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent <= '0;
      end else if (!stall) begin
         if (flush) begin
            ent.valid <= 1'b0;
         end else begin
            ent.valid   <= d_valid;
            ent.pc      <= d_pc;
            ent.predict <= d_predict;
            ent.target  <= d_target;
         end
      end
   end

   assign q_valid   = ent.valid;
   assign q_pc      = ent.pc;
   assign q_predict = ent.predict;
   assign q_target  = ent.target;

endmodule

// File: rtl/branch_resolver.sv
// Consumer end of the branch predictor interface. Carries each fetch-stage
// prediction through IF/ID and ID/EX, checks it against the real outcome in
// EX, redirects fetch on a mispredict and trains the predictor.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   if_valid/if_pc/if_predict/if_predict_target : prediction leaving IF
//   stall                         : shadow stages hold, no resolution
//   ex_resolve/ex_taken/ex_target : actual branch outcome in EX
//   redirect/redirect_pc          : combinational restart request (EX cycle)
//   update/br/update_pc/update_target : registered one-cycle training strobe
//   stat_branches/stat_mispredicts: saturating statistics counters
// Handshake: no back-pressure. update is a single-cycle strobe the predictor
// must accept unconditionally; redirect is valid only in the cycle it is high.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_valid,
   input  logic [31:0]          if_pc,
   input  logic                 if_predict,
   input  logic [31:0]          if_predict_target,
   input  logic                 stall,
   input  logic                 ex_resolve,
   input  logic                 ex_taken,
   input  logic [31:0]          ex_target,
   output logic                 redirect,
   output logic [31:0]          redirect_pc,
   output logic                 update,
   output logic                 br,
   output logic [31:0]          update_pc,
   output logic [31:0]          update_target,
   output logic [CNT_WIDTH-1:0] stat_branches,
   output logic [CNT_WIDTH-1:0] stat_mispredicts
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   pred_entry_t id_entry;
   pred_entry_t ex_entry;

   logic active;
   logic act_taken;
   logic mispredict;
   logic resolve_fire;
   logic train_fire;

   pred_stage_reg u_if_id (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .flush     (mispredict),
      .d_valid   (if_valid),
      .d_pc      (if_pc),
      .d_predict (if_predict),
      .d_target  (if_predict_target),
      .q_valid   (id_entry.valid),
      .q_pc      (id_entry.pc),
      .q_predict (id_entry.predict),
      .q_target  (id_entry.target)
   );

   pred_stage_reg u_id_ex (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .flush     (mispredict),
      .d_valid   (id_entry.valid),
      .d_pc      (id_entry.pc),
      .d_predict (id_entry.predict),
      .d_target  (id_entry.target),
      .q_valid   (ex_entry.valid),
      .q_pc      (ex_entry.pc),
      .q_predict (ex_entry.predict),
      .q_target  (ex_entry.target)
   );

   // A non-resolving instruction behaves as "not taken", which folds the
   // alias-hit case into the ordinary direction mismatch check.
   always_comb begin
      active       = ex_entry.valid && !stall;
      act_taken    = ex_resolve && ex_taken;
      mispredict   = active &&
                     ((ex_entry.predict != act_taken) ||
                      (ex_entry.predict && act_taken && (ex_entry.target != ex_target)));
      resolve_fire = active && ex_resolve;
      train_fire   = active && (ex_resolve || ex_entry.predict);
      redirect     = mispredict;
      redirect_pc  = 32'd0;
      if (mispredict) begin
         redirect_pc = act_taken ? ex_target : (ex_entry.pc + PC_STEP);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         update        <= 1'b0;
         br            <= 1'b0;
         update_pc     <= 32'd0;
         update_target <= 32'd0;
      end else begin
         update <= train_fire;
         if (train_fire) begin
            br            <= act_taken;
            update_pc     <= ex_entry.pc;
            update_target <= ex_resolve ? ex_target : 32'd0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (resolve_fire && (stat_branches != CNT_MAX)) begin
            stat_branches <= stat_branches + 1'b1;
         end
         if (mispredict && (stat_mispredicts != CNT_MAX)) begin
            stat_mispredicts <= stat_mispredicts + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized bench for branch_resolver. The reference model keeps the
// in-flight predictions as a two-deep queue and judges each EX entry from
// the prediction rules (direction + target agreement).
module tb_branch_resolver;
   import branch_pkg::*;

   localparam int CW = 4;  // narrow counters so saturation is reached

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_valid = 1'b0;
   logic [31:0]   if_pc = '0;
   logic          if_predict = 1'b0;
   logic [31:0]   if_predict_target = '0;
   logic          stall = 1'b0;
   logic          ex_resolve = 1'b0;
   logic          ex_taken = 1'b0;
   logic [31:0]   ex_target = '0;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          update;
   logic          br;
   logic [31:0]   update_pc;
   logic [31:0]   update_target;
   logic [CW-1:0] stat_branches;
   logic [CW-1:0] stat_mispredicts;

   branch_resolver #(.CNT_WIDTH(CW)) dut (
      .clk               (clk),
      .rst               (rst),
      .if_valid          (if_valid),
      .if_pc             (if_pc),
      .if_predict        (if_predict),
      .if_predict_target (if_predict_target),
      .stall             (stall),
      .ex_resolve        (ex_resolve),
      .ex_taken          (ex_taken),
      .ex_target         (ex_target),
      .redirect          (redirect),
      .redirect_pc       (redirect_pc),
      .update            (update),
      .br                (br),
      .update_pc         (update_pc),
      .update_target     (update_target),
      .stat_branches     (stat_branches),
      .stat_mispredicts  (stat_mispredicts)
   );

   // clock / reset
   always #5 clk = ~clk;

   // scoreboard state
   int          pass_cnt = 0;
   int          total_cnt = 0;
   pred_entry_t pipe_q[$];          // [0] youngest, [$] entry in EX
   logic        exp_update;
   logic        exp_br;
   logic [31:0] exp_upc;
   logic [31:0] exp_utgt;
   int          exp_nb;
   int          exp_nm;
   int          cnt_max = (1 << CW) - 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      pred_entry_t e;
      e = '0;
      pipe_q = '{e, e};
      exp_update = 1'b0;
      exp_br = 1'b0;
      exp_upc = '0;
      exp_utgt = '0;
      exp_nb = 0;
      exp_nm = 0;
   endtask

   task automatic check_regs();
      check_eq("update", {31'd0, update}, {31'd0, exp_update});
      check_eq("br", {31'd0, br}, {31'd0, exp_br});
      check_eq("update_pc", update_pc, exp_upc);
      check_eq("update_target", update_target, exp_utgt);
      check_eq("stat_branches", 32'(stat_branches), 32'(exp_nb));
      check_eq("stat_mispredicts", 32'(stat_mispredicts), 32'(exp_nm));
   endtask

   // One clock cycle: check registered outputs, drive inputs, check the
   // combinational redirect, then advance the model past the next edge.
   task automatic step(input logic v, input logic [31:0] pc, input logic pr,
                       input logic [31:0] tgt, input logic st, input logic res,
                       input logic tk, input logic [31:0] xt);
      pred_entry_t ex, nw, tmp;
      logic actual_taken, mis, live;
      logic [31:0] rpc;
      @(negedge clk);
      check_regs();
      if_valid = v; if_pc = pc; if_predict = pr; if_predict_target = tgt;
      stall = st; ex_resolve = res; ex_taken = tk; ex_target = xt;
      #1;
      ex = pipe_q[$];
      live = ex.valid && !st;
      actual_taken = res && tk;
      mis = live && ((ex.predict != actual_taken) ||
                     (ex.predict && actual_taken && ex.target != xt));
      rpc = !mis ? 32'd0 : (actual_taken ? xt : ex.pc + 32'd4);
      check_eq("redirect", {31'd0, redirect}, {31'd0, mis});
      check_eq("redirect_pc", redirect_pc, rpc);
      exp_update = live && (res || ex.predict);
      if (exp_update) begin
         exp_br = actual_taken;
         exp_upc = ex.pc;
         exp_utgt = res ? xt : 32'd0;
      end
      if (live && res && exp_nb < cnt_max) exp_nb++;
      if (mis && exp_nm < cnt_max) exp_nm++;
      if (!st) begin
         if (mis) begin
            pipe_q[0].valid = 1'b0;
            pipe_q[1].valid = 1'b0;
         end else begin
            nw.valid = v; nw.pc = pc; nw.predict = pr; nw.target = tgt;
            pipe_q.push_front(nw);
            tmp = pipe_q.pop_back();
         end
      end
   endtask

   task automatic bubble();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   // Reset asserted mid-cycle: outputs must clear at once.
   task automatic do_reset();
      @(negedge clk);
      check_regs();
      if_valid = 1'b0; stall = 1'b0; ex_resolve = 1'b0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_regs();
      check_eq("rst_redirect", {31'd0, redirect}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_regs();
      rst = 1'b0;

      // correct prediction
      step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0);
      bubble();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h200);
      check_eq("t1_redirect", {31'd0, redirect}, 32'd0);
      bubble();
      check_eq("t1_upc", update_pc, 32'h100);
      check_eq("t1_utgt", update_target, 32'h200);

      // predicted taken, actually not taken; the IF entry that cycle is dropped
      step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'd0);
      bubble();
      step(1'b1, 32'h300, 1'b1, 32'h900, 1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("t2_rpc", redirect_pc, 32'h104);
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0);
      check_eq("t2_shadow", {31'd0, redirect}, 32'd0);

      // wrong target
      step(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'd0);
      bubble();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'hC0);
      check_eq("t3_rpc", redirect_pc, 32'hC0);

      // mispredict held by stall for three cycles
      step(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 32'd0);
      bubble();
      for (int i = 0; i < 3; i++)
         step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
      check_eq("t4_rpc", redirect_pc, 32'h504);
      bubble();
      bubble();

      // alias hit on a non-branch with PC wrap
      step(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1234, 1'b0, 1'b0, 1'b0, 32'd0);
      bubble();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h55);
      check_eq("t5_redirect", {31'd0, redirect}, 32'd1);
      check_eq("t5_rpc", redirect_pc, 32'h0);
      bubble();
      check_eq("t5_utgt", update_target, 32'h0);

      // reset right after a resolving cycle
      step(1'b1, 32'h700, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      bubble();
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0);
      do_reset();
      bubble();
      bubble();

      // randomized traffic; small value sets so targets often agree
      for (int n = 0; n < 600; n++) begin
         logic [31:0] pc, tgt, xt;
         pc  = {$urandom_range(0, 15), 2'b00};
         pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : pc;
         tgt = {$urandom_range(0, 3), 4'h0};
         xt  = {$urandom_range(0, 3), 4'h0};
         step(1'($urandom_range(0, 3) != 0), pc, 1'($urandom_range(0, 1)), tgt,
              1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 1)), xt);
         if ($urandom_range(0, 150) == 0) do_reset();
      end

      @(negedge clk);
      check_regs();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
